gate_exerciser: RTL and testbench

Self-checking stimulus sequencer for the lab's 2-bit gate set (NOT, AND, OR, NAND, NOR, XOR, XNOR). It drives every input combination into the gates under test, waits a fixed settle interval, and samples the seven gate outputs. Each sample is compared against an internal golden model, and the block reports a pass/fail verdict with an error count and the first failing vector. It sits directly upstream of the gate modules, replacing hand-written `#10` stimulus so the gates can be exercised on a board or in a clocked bench.

---
 rtl/gate_ex_pkg.sv | 25 ++
 rtl/gate_ex_golden.sv | 23 ++
 rtl/gate_exerciser.sv | 124 ++++++++++++
 tb/tb_gate_exerciser.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/gate_ex_pkg.sv
// Shared types for the gate exerciser: FSM states, vector count, gate output bundle.
// No logic, no latency; types only.
package gate_ex_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam int NUM_VECTORS = 32;
    localparam int VEC_W       = $clog2(NUM_VECTORS);

    typedef struct packed {
        logic       y_not;
        logic [1:0] y_and;
        logic [1:0] y_or;
        logic [1:0] y_nand;
        logic [1:0] y_nor;
        logic [1:0] y_xor;
        logic [1:0] y_xnor;
    } gate_out_t;

endpackage

// File: rtl/gate_ex_golden.sv
// Golden model of the 2-bit gate set; expected outputs for one stimulus vector.
// Purely combinational, zero latency, no flow control.
module gate_ex_golden
    import gate_ex_pkg::*;
(
    input  logic [1:0] a,
    input  logic [1:0] b,
    input  logic       in,
    output gate_out_t  y
);

    always_comb begin
        y        = '0;
        y.y_not  = ~in;
        y.y_and  = a & b;
        y.y_or   = a | b;
        y.y_nand = ~(a & b);
        y.y_nor  = ~(a | b);
        y.y_xor  = a ^ b;
        y.y_xnor = ~(a ^ b);
    end

endmodule

// File: rtl/gate_exerciser.sv
// Sweeps all 32 gate input vectors, settles, compares against the golden model, reports verdict.
// Run length 32*(SETTLE_CYCLES+1) cycles; start is ignored while busy, accepted in IDLE/DONE.
// Define GATE_EX_STOP_ON_FAIL_EN to end the run at the first failing vector.
module gate_exerciser
    import gate_ex_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [1:0]       a_o,
    output logic [1:0]       b_o,
    output logic             in_o,
    input  logic             y_not,
    input  logic [1:0]       y_and,
    input  logic [1:0]       y_or,
    input  logic [1:0]       y_nand,
    input  logic [1:0]       y_nor,
    input  logic [1:0]       y_xor,
    input  logic [1:0]       y_xnor,
    output logic [ERR_W-1:0] err_count,
    output logic [4:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam int                CNT_W       = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0]  LAST_VEC    = VEC_W'(NUM_VECTORS - 1);
    localparam logic [ERR_W-1:0]  ERR_MAX     = '1;

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic [CNT_W-1:0] settle_cnt;
    gate_out_t        expected;
    gate_out_t        observed;
    logic             mismatch;
    logic             stop_on_fail;
    logic [ERR_W-1:0] err_inc;

    assign a_o  = vec[4:3];
    assign b_o  = vec[2:1];
    assign in_o = vec[0];

    gate_ex_golden u_golden (
        .a  (a_o),
        .b  (b_o),
        .in (in_o),
        .y  (expected)
    );

    assign observed = {y_not, y_and, y_or, y_nand, y_nor, y_xor, y_xnor};
    assign mismatch = (observed != expected);
    assign err_inc  = (err_count == ERR_MAX) ? err_count : err_count + 1'b1;

`ifdef GATE_EX_STOP_ON_FAIL_EN
    assign stop_on_fail = 1'b1;
`else
    assign stop_on_fail = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            vec              <= '0;
            settle_cnt       <= '0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_count        <= '0;
            first_fail_vec   <= '0;
            first_fail_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state            <= SETTLE;
                        vec              <= '0;
                        settle_cnt       <= '0;
                        busy             <= 1'b1;
                        done             <= 1'b0;
                        pass             <= 1'b0;
                        err_count        <= '0;
                        first_fail_vec   <= '0;
                        first_fail_valid <= 1'b0;
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state      <= CHECK;
                        settle_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        err_count <= err_inc;
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec;
                            first_fail_valid <= 1'b1;
                        end
                    end
                    // The verdict must include this cycle's compare, hence err_count==0 plus !mismatch.
                    if (vec == LAST_VEC || (mismatch && stop_on_fail)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !mismatch && (err_count == '0);
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= SETTLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// Randomized and directed bench for gate_exerciser against a vector-level reference model.
// Honours GATE_EX_STOP_ON_FAIL_EN when building its expectations.
module tb_gate_exerciser;

    localparam int S = 2;
`ifdef GATE_EX_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       busy, done, pass, in_o, first_fail_valid;
    logic [1:0] a_o, b_o;
    logic [5:0] err_count;
    logic [4:0] first_fail_vec;
    logic       s_busy, s_done, s_pass, s_in, s_ffv;
    logic [1:0] s_a, s_b;
    logic [3:0] s_err;
    logic [4:0] s_ffvec;
    logic       y_not;
    logic [1:0] y_and, y_or, y_nand, y_nor, y_xor, y_xnor;
    logic [4:0] idx;

    int          fault;
    logic [31:0] corrupt;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    // Gates under test: correct gates with an optional injected fault.
    always_comb begin
        idx    = {a_o, b_o, in_o};
        y_not  = (fault == 2) ? in_o : ~in_o;
        y_and  = (fault == 1) ? 2'b00 : (a_o & b_o);
        y_or   = a_o | b_o;
        y_nand = ~(a_o & b_o);
        y_nor  = ~(a_o | b_o);
        y_xor  = (a_o ^ b_o) ^ {1'b0, (fault == 3) && corrupt[idx]};
        y_xnor = ~(a_o ^ b_o);
    end

    gate_exerciser #(.SETTLE_CYCLES(S), .ERR_W(6)) u_dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .a_o(a_o), .b_o(b_o), .in_o(in_o),
        .y_not(y_not), .y_and(y_and), .y_or(y_or), .y_nand(y_nand), .y_nor(y_nor),
        .y_xor(y_xor), .y_xnor(y_xnor),
        .err_count(err_count), .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid)
    );

    gate_exerciser #(.SETTLE_CYCLES(S), .ERR_W(4)) u_sat (
        .clk(clk), .rst(rst), .start(start), .busy(s_busy), .done(s_done), .pass(s_pass),
        .a_o(s_a), .b_o(s_b), .in_o(s_in),
        .y_not(y_not), .y_and(y_and), .y_or(y_or), .y_nand(y_nand), .y_nor(y_nor),
        .y_xor(y_xor), .y_xnor(y_xnor),
        .err_count(s_err), .first_fail_vec(s_ffvec), .first_fail_valid(s_ffv)
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Does vector v expose the currently injected fault?
    function automatic bit fails(input int v);
        logic [4:0] vv;
        vv = 5'(v);
        case (fault)
            1:       return (vv[4:3] & vv[2:1]) != 2'b00;
            2:       return 1'b1;
            3:       return corrupt[vv];
            default: return 1'b0;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_vec"}, idx, 0);
        check({tag, "_err"}, err_count, 0);
        check({tag, "_ffvec"}, first_fail_vec, 0);
        check({tag, "_ffvalid"}, first_fail_valid, 0);
    endtask

    task automatic run_and_check(input string name, input int f, input bit repulse);
        int errs, first, last, exp_cycles, n;
        fault = f;
        errs  = 0;
        first = -1;
        last  = 31;
        for (int v = 0; v < 32; v++) begin
            if (fails(v)) begin
                errs++;
                if (first < 0) first = v;
                if (STOP) begin
                    last = v;
                    break;
                end
            end
        end
        exp_cycles = (last + 1) * (S + 1) + 1;

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({name, "_start_busy"}, busy, 1);
        check({name, "_start_err_clr"}, err_count, 0);
        check({name, "_start_ff_clr"}, first_fail_valid, 0);
        n = 1;
        while (done !== 1'b1 && n < 400) begin
            check({name, "_vec"}, idx, (n - 1) / (S + 1));
            start = repulse && (n == 30);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({name, "_cycles"}, n, exp_cycles);
        check({name, "_done"}, done, 1);
        check({name, "_busy"}, busy, 0);
        check({name, "_pass"}, pass, (errs == 0) ? 1 : 0);
        check({name, "_err"}, err_count, (errs > 63) ? 63 : errs);
        check({name, "_err_sat4"}, s_err, (errs > 15) ? 15 : errs);
        check({name, "_ffvalid"}, first_fail_valid, (first >= 0) ? 1 : 0);
        check({name, "_ffvec"}, first_fail_vec, (first >= 0) ? first : 0);
        check({name, "_last_vec"}, idx, last);
        @(negedge clk);
        check({name, "_done_hold"}, done, 1);
        check({name, "_vec_hold"}, idx, last);
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        start   = 1'b0;
        fault   = 0;
        corrupt = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_all_zero("idle");

        run_and_check("clean", 0, 1'b0);
        run_and_check("and_stuck0", 1, 1'b0);
        run_and_check("not_inverted", 2, 1'b0);
        run_and_check("clean_after_done", 0, 1'b1);

        // Reset in the middle of a run, at vector 12.
        fault = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!(busy === 1'b1 && idx == 5'd12) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reach_vec12", (n < 200) ? 1 : 0, 1);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midrun_rst");
        rst = 1'b0;
        run_and_check("clean_after_rst", 0, 1'b0);

        // rst and start together: rst wins.
        @(negedge clk) begin rst = 1'b1; start = 1'b1; end
        @(negedge clk) begin rst = 1'b0; start = 1'b0; end
        check_all_zero("rst_start");

        for (int r = 0; r < 6; r++) begin
            corrupt = (r == 0) ? 32'h0 : ($urandom & $urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_and_check("random", 3, ($urandom_range(0, 1) == 1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
